// File: rtl/xy_pkg.sv
// Shared types and limits for the x/y handshake stimulus generator.
package xy_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BOTH, DROP} xy_state_t;

  localparam int XY_MAX_LAT = 255;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xy_lat_counter.sv
// Loadable up-counter with synchronous clear, enable and a terminal-count compare.
module xy_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/xy_handshake_gen.sv
// Drives x, then y LATENCY clocks later, holds both for HOLD clocks, then reports completion.
//   state | meaning
//   IDLE  | waiting for start; x=y=0
//   WAIT  | x high, counting LATENCY clocks toward y
//   BOTH  | x and y high for HOLD clocks
//   DROP  | x=y=0, done pulse; count bumps on exit unless aborted
module xy_handshake_gen
  import xy_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int HOLD    = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             y_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] txn_count_o
);

  localparam int CW = $clog2(max2(LATENCY, HOLD) + 1);
  localparam logic [CW-1:0] LAT_TC  = CW'(LATENCY - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD - 1);

  if (LATENCY < 1 || HOLD < 1 || LATENCY > XY_MAX_LAT || HOLD > XY_MAX_LAT) begin : g_bad_param
    $error("xy_handshake_gen: LATENCY and HOLD must be in 1..255");
  end

  xy_state_t        state_q, state_d;
  logic             x_q, x_d, y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ab_q, ab_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lat_clr, lat_en, lat_tc;
  logic             hold_clr, hold_en, hold_tc;

  xy_lat_counter #(.W(CW)) u_lat (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (lat_clr),
    .load_i     (1'b0),
    .load_val_i ({CW{1'b0}}),
    .en_i       (lat_en),
    .term_i     (LAT_TC),
    .tc_o       (lat_tc)
  );

  xy_lat_counter #(.W(CW)) u_hold (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (hold_clr),
    .load_i     (1'b0),
    .load_val_i ({CW{1'b0}}),
    .en_i       (hold_en),
    .term_i     (HOLD_TC),
    .tc_o       (hold_tc)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    done_d   = 1'b0;
    ab_d     = 1'b0;
    cnt_d    = cnt_q;
    lat_clr  = 1'b0;
    lat_en   = 1'b0;
    hold_clr = 1'b0;
    hold_en  = 1'b0;

    if (state_q != IDLE && abort_i) begin
      // Abort beats everything, including the count bump on DROP exit.
      state_d = IDLE;
      x_d     = 1'b0;
      y_d     = 1'b0;
      ab_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_d = WAIT;
            x_d     = 1'b1;
            y_d     = 1'b0;
            lat_clr = 1'b1;
          end
        end
        WAIT: begin
          if (lat_tc) begin
            state_d  = BOTH;
            y_d      = 1'b1;
            hold_clr = 1'b1;
          end else begin
            lat_en = 1'b1;
          end
        end
        BOTH: begin
          if (hold_tc) begin
            state_d = DROP;
            x_d     = 1'b0;
            y_d     = 1'b0;
            done_d  = 1'b1;
          end else begin
            hold_en = 1'b1;
          end
        end
        DROP: begin
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = ab_q;
  assign txn_count_o = cnt_q;

endmodule
